// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage_if
//  Brief    : EX-side request and MEM/WB-side result bundle of mem_wb_stage.
//  Revision : 1.0
// ============================================================================
interface mem_wb_stage_if;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        flush;
    logic        mem_busy;
    logic        m_fwd_valid;
    logic [4:0]  m_fwd_rd;
    logic [31:0] m_fwd_data;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_fault;

    modport master (
        output ex_valid, ex_alu_result, ex_store_data, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, flush,
        input  mem_busy, m_fwd_valid, m_fwd_rd, m_fwd_data, wb_valid,
               wb_reg_write, wb_rd, wb_data, misalign_fault
    );

    modport slave (
        input  ex_valid, ex_alu_result, ex_store_data, ex_rd, ex_reg_write,
               ex_mem_read, ex_mem_write, flush,
        output mem_busy, m_fwd_valid, m_fwd_rd, m_fwd_data, wb_valid,
               wb_reg_write, wb_rd, wb_data, misalign_fault
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wb_stage
//  Brief    : EX/MEM + MEM/WB pipeline registers with a wait-stated data RAM.
//  Revision : 1.0
// ============================================================================
module mem_wb_stage #(
    parameter int DEPTH       = 256,
    parameter int ADDR_BITS   = 8,
    parameter int MEM_LATENCY = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mem_wb_stage_if.slave      bus
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam int               CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               m_valid_q, m_reg_write_q, m_mem_read_q, m_mem_write_q;
    logic [31:0]        m_alu_q, m_store_q;
    logic [4:0]         m_rd_q;

    logic               w_valid_q, w_reg_write_q;
    logic [4:0]         w_rd_q;
    logic [31:0]        w_data_q;

    logic [31:0]        mem [DEPTH];

    logic               ex_take, ex_is_store, ex_aligned_memop;
    logic               access_done, busy, m_misalign;
    logic [ADDR_BITS-1:0] m_index;

    assign ex_take          = bus.ex_valid & ~bus.flush;
    assign ex_is_store      = bus.ex_mem_write & ~bus.ex_mem_read;
    assign ex_aligned_memop = ex_take & (bus.ex_mem_read | bus.ex_mem_write)
                              & (bus.ex_alu_result[1:0] == 2'b00);

    // The completing edge frees M, so the stage only stalls on earlier edges.
    assign access_done = (state_q == S_ACCESS) && (cnt_q == CNT_LAST);
    assign busy        = (state_q == S_ACCESS) && !access_done;
    assign m_misalign  = m_valid_q & (m_mem_read_q | m_mem_write_q) & (m_alu_q[1:0] != 2'b00);
    assign m_index     = m_alu_q[ADDR_BITS+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ex_aligned_memop) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                end
            end
            S_ACCESS: begin
                if (!access_done) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (ex_aligned_memop) begin
                    cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q     <= 1'b0;
            m_reg_write_q <= 1'b0;
            m_mem_read_q  <= 1'b0;
            m_mem_write_q <= 1'b0;
            m_alu_q       <= '0;
            m_store_q     <= '0;
            m_rd_q        <= '0;
        end else if (!busy) begin
            m_valid_q     <= ex_take;
            m_reg_write_q <= bus.ex_reg_write & (bus.ex_rd != 5'd0) & ~ex_is_store;
            m_mem_read_q  <= bus.ex_mem_read;
            m_mem_write_q <= ex_is_store;
            m_alu_q       <= bus.ex_alu_result;
            m_store_q     <= bus.ex_store_data;
            m_rd_q        <= bus.ex_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid_q     <= 1'b0;
            w_reg_write_q <= 1'b0;
            w_rd_q        <= '0;
            w_data_q      <= '0;
        end else if (busy) begin
            w_valid_q     <= 1'b0;
            w_reg_write_q <= 1'b0;
        end else begin
            w_valid_q     <= m_valid_q;
            w_reg_write_q <= m_valid_q & m_reg_write_q & ~m_misalign;
            w_rd_q        <= m_rd_q;
            w_data_q      <= (access_done && m_mem_read_q) ? mem[m_index] : m_alu_q;
        end
    end

    // Contents survive reset; a store caught by reset is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst && access_done && m_mem_write_q) begin
            mem[m_index] <= m_store_q;
        end
    end

    assign bus.mem_busy       = busy;
    assign bus.m_fwd_valid    = m_valid_q & m_reg_write_q & ~m_mem_read_q;
    assign bus.m_fwd_rd       = m_rd_q;
    assign bus.m_fwd_data     = m_alu_q;
    assign bus.wb_valid       = w_valid_q;
    assign bus.wb_reg_write   = w_valid_q & w_reg_write_q;
    assign bus.wb_rd          = w_rd_q;
    assign bus.wb_data        = w_data_q;
    assign bus.misalign_fault = m_misalign;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_wb_stage
//  Brief    : Directed self-checking bench for mem_wb_stage (MEM_LATENCY=2).
//  Revision : 1.0
// ============================================================================
module tb_mem_wb_stage;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mem_wb_stage_if bus ();

    mem_wb_stage #(
        .DEPTH       (256),
        .ADDR_BITS   (8),
        .MEM_LATENCY (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                            input logic rw, input logic mr, input logic mw);
        bus.ex_valid      = 1'b1;
        bus.ex_alu_result = alu;
        bus.ex_store_data = sd;
        bus.ex_rd         = rd;
        bus.ex_reg_write  = rw;
        bus.ex_mem_read   = mr;
        bus.ex_mem_write  = mw;
    endtask

    task automatic idle_ex();
        bus.ex_valid      = 1'b0;
        bus.ex_alu_result = 32'd0;
        bus.ex_store_data = 32'd0;
        bus.ex_rd         = 5'd0;
        bus.ex_reg_write  = 1'b0;
        bus.ex_mem_read   = 1'b0;
        bus.ex_mem_write  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".mem_busy"},     32'(bus.mem_busy),       32'd0);
        check_eq({tag, ".m_fwd_valid"},  32'(bus.m_fwd_valid),    32'd0);
        check_eq({tag, ".m_fwd_rd"},     32'(bus.m_fwd_rd),       32'd0);
        check_eq({tag, ".m_fwd_data"},   bus.m_fwd_data,          32'd0);
        check_eq({tag, ".wb_valid"},     32'(bus.wb_valid),       32'd0);
        check_eq({tag, ".wb_reg_write"}, 32'(bus.wb_reg_write),   32'd0);
        check_eq({tag, ".wb_rd"},        32'(bus.wb_rd),          32'd0);
        check_eq({tag, ".wb_data"},      bus.wb_data,             32'd0);
        check_eq({tag, ".misalign"},     32'(bus.misalign_fault), 32'd0);
    endtask

    task automatic check_wb(input string tag, input logic v, input logic rw,
                            input logic [4:0] rd, input logic [31:0] data);
        check_eq({tag, ".wb_valid"},     32'(bus.wb_valid),     32'(v));
        check_eq({tag, ".wb_reg_write"}, 32'(bus.wb_reg_write), 32'(rw));
        check_eq({tag, ".wb_rd"},        32'(bus.wb_rd),        32'(rd));
        check_eq({tag, ".wb_data"},      bus.wb_data,           data);
    endtask

    // Full store-then-writeback sequence for an aligned store at latency 2.
    task automatic do_store(input logic [31:0] addr, input logic [31:0] val);
        drive_ex(addr, val, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        idle_ex();
        tick();
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        bus.flush = 1'b0;
        idle_ex();

        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // ALU op: visible in M after one edge, in W after two.
        drive_ex(32'd899, 32'd0, 5'd20, 1'b1, 1'b0, 1'b0);
        tick();
        idle_ex();
        check_eq("alu.m_fwd_valid", 32'(bus.m_fwd_valid), 32'd1);
        check_eq("alu.m_fwd_rd",    32'(bus.m_fwd_rd),    32'd20);
        check_eq("alu.m_fwd_data",  bus.m_fwd_data,       32'd899);
        check_eq("alu.wb_early",    32'(bus.wb_valid),    32'd0);
        tick();
        check_wb("alu.w", 1'b1, 1'b1, 5'd20, 32'd899);
        check_eq("alu.m_fwd_gone",  32'(bus.m_fwd_valid), 32'd0);

        // Store 1019 @0x10, load held upstream while busy, then completes.
        drive_ex(32'h10, 32'd1019, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("st.busy_e0", 32'(bus.mem_busy), 32'd1);
        drive_ex(32'h10, 32'd0, 5'd15, 1'b1, 1'b1, 1'b0);
        tick();
        check_eq("st.busy_e1",   32'(bus.mem_busy), 32'd0);
        check_eq("st.bubble_e1", 32'(bus.wb_valid), 32'd0);
        tick();
        idle_ex();
        check_wb("st.w", 1'b1, 1'b0, 5'd0, 32'h10);
        check_eq("ld.busy_e0",  32'(bus.mem_busy),    32'd1);
        check_eq("ld.no_fwd",   32'(bus.m_fwd_valid), 32'd0);
        tick();
        check_eq("ld.busy_e1",  32'(bus.mem_busy), 32'd0);
        check_eq("ld.bubble",   32'(bus.wb_valid), 32'd0);
        tick();
        check_wb("ld.w", 1'b1, 1'b1, 5'd15, 32'd1019);

        // Misaligned load and store: fault pulse, no stall, no memory update.
        drive_ex(32'h12, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0);
        tick();
        idle_ex();
        check_eq("mis.fault", 32'(bus.misalign_fault), 32'd1);
        check_eq("mis.busy",  32'(bus.mem_busy),       32'd0);
        tick();
        check_eq("mis.fault_end", 32'(bus.misalign_fault), 32'd0);
        check_wb("mis.w", 1'b1, 1'b0, 5'd9, 32'h12);
        drive_ex(32'h12, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        idle_ex();
        check_eq("mis_st.fault", 32'(bus.misalign_fault), 32'd1);
        check_eq("mis_st.busy",  32'(bus.mem_busy),       32'd0);
        tick();
        drive_ex(32'h10, 32'd0, 5'd15, 1'b1, 1'b1, 1'b0);
        tick();
        idle_ex();
        tick();
        tick();
        check_wb("mem4_kept", 1'b1, 1'b1, 5'd15, 32'd1019);

        // rd=0 suppresses the register write.
        drive_ex(32'd5, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        idle_ex();
        check_eq("rd0.m_fwd_valid", 32'(bus.m_fwd_valid), 32'd0);
        tick();
        check_wb("rd0.w", 1'b1, 1'b0, 5'd0, 32'd5);

        // Flush of a non-busy EX op squashes it.
        drive_ex(32'd7, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        idle_ex();
        check_eq("flush.m_fwd_valid", 32'(bus.m_fwd_valid), 32'd0);
        tick();
        check_eq("flush.wb_valid", 32'(bus.wb_valid), 32'd0);

        // Flush while busy does not touch the in-flight load.
        drive_ex(32'h10, 32'd0, 5'd15, 1'b1, 1'b1, 1'b0);
        tick();
        idle_ex();
        bus.flush = 1'b1;
        check_eq("bflush.busy", 32'(bus.mem_busy), 32'd1);
        tick();
        bus.flush = 1'b0;
        check_eq("bflush.bubble", 32'(bus.wb_valid), 32'd0);
        tick();
        check_wb("bflush.w", 1'b1, 1'b1, 5'd15, 32'd1019);

        // Reset on the completing edge of a store abandons it.
        do_store(32'h20, 32'd0);
        drive_ex(32'h20, 32'd42, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        idle_ex();
        check_eq("rst_st.busy", 32'(bus.mem_busy), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("mid_rst");
        rst = 1'b0;
        drive_ex(32'h20, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        idle_ex();
        tick();
        tick();
        check_wb("rst_st.ld", 1'b1, 1'b1, 5'd7, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline stage directly downstream of the datapath's ALU.
- Latches the executed instruction into an EX/MEM register and performs load/store against an internal word-addressed data memory with configurable wait states.
- Delivers the write-back result through a MEM/WB register to the register bank.
- Exposes forwarding taps and a busy signal that the upstream stages use to stall.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory (power of 2).
- ADDR_BITS, 8, log2(DEPTH); word index = ex_alu_result[ADDR_BITS+1:2].
- MEM_LATENCY, 2, cycles a load/store occupies the MEM stage (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- ex_valid  in  1  EX-stage instruction valid.
- ex_alu_result  in  32  ALU result / effective byte address.
- ex_store_data  in  32  rt value for stores.
- ex_rd  in  5  destination register.
- ex_reg_write  in  1  instruction writes a register.
- ex_mem_read  in  1  load word.
- ex_mem_write  in  1  store word.
- flush  in  1  discard the EX instruction presented this cycle.
- mem_busy  out  1  MEM stage occupied by an unfinished access; upstream must hold.
- m_fwd_valid  out  1  M holds a valid non-load register-writing op.
- m_fwd_rd  out  5  rd of M.
- m_fwd_data  out  32  ALU result held in M.
- wb_valid  out  1  W holds a valid instruction.
- wb_reg_write  out  1  write enable to the register bank.
- wb_rd  out  5  register-bank write address.
- wb_data  out  32  write-back data (load data or ALU result).
- misalign_fault  out  1  one-cycle pulse: mem op with address[1:0] != 0.

Behaviour:
- Reset (rst=1 at clk edge):
  - M and W valid cleared; FSM to IDLE; wait counter to 0.
  - All outputs 0.
  - Memory contents are not reset.
- Capture into M: at an edge with mem_busy=0, M loads the EX fields, with M.valid = ex_valid & ~flush. When mem_busy=1, EX inputs are ignored and M holds.
- ex_reg_write is forced to 0 when ex_rd == 0.
- ex_mem_read and ex_mem_write both set: treated as a load (the store is ignored).
- FSM has two states:
  - IDLE: M is empty or holds a non-mem op. The op passes to W at the next edge, giving EX->W latency of 2 edges.
  - ACCESS: entered at the edge M captures a valid aligned mem op. mem_busy=1 while in ACCESS. The counter counts 1..MEM_LATENCY. On the edge where the count reaches MEM_LATENCY, the access completes: a store writes mem[index]; a load reads mem[index] into W.data. W gets the op, the FSM returns to IDLE, and M may capture a new EX op at that same edge.
- MEM_LATENCY=1: no busy cycle; a mem op behaves like a non-mem op.
- Busy cycles: each edge during ACCESS that does not complete the access loads a bubble into W (wb_valid=0).
- Misaligned mem op:
  - No memory access and no ACCESS state.
  - misalign_fault=1 during the cycle the op sits in M.
  - The op reaches W with reg_write=0 and wb_valid=1.
- W contents:
  - wb_data = load data for loads, otherwise the ALU result.
  - wb_reg_write = valid & reg_write.
  - A completed store produces wb_valid=1, wb_reg_write=0.
- Forwarding: m_fwd_valid = M.valid & M.reg_write & ~M.mem_read. Loads are never forwarded from M.
- flush is ignored while mem_busy=1, because the in-flight op has already committed.
- Reset during ACCESS: the access is abandoned and a pending store is not written.

Test Plan:
- Reset, then ALU op (result 899, rd=20, reg_write) -> 2 edges later wb_valid=1, wb_rd=20, wb_data=899; m_fwd_data=899 for one cycle before that.
- Store 1019 to address 0x10, then load from 0x10 into rd=15, with MEM_LATENCY=2 -> mem_busy high 1 cycle per access; load W shows wb_rd=15, wb_data=1019; store W shows wb_reg_write=0.
- Load with address 0x12 -> misalign_fault pulses 1 cycle; no mem_busy; wb_reg_write=0; mem[4] unchanged.
- ALU op with rd=0, result 5 -> wb_valid=1, wb_reg_write=0.
- flush=1 with a valid EX op (result 7, rd=3) -> wb_valid stays 0; a flush asserted while mem_busy=1 has no effect on the in-flight op.
- rst asserted mid-ACCESS of a store of 42 to 0x20 -> all outputs 0 next cycle; a later load of 0x20 does not return 42 (preload 0 first).
